register_write_queue: RTL and testbench

Buffered write front-end for the multi-port register file. Accepts write requests (address, data) over a valid/ready handshake and holds them in an in-order FIFO of `DEPTH` entries. Drains one entry per cycle onto one register-file write port (write strobe, write address, write data), so producers are decoupled from write-port stalls. An optional forwarding port lets readers see pending writes not yet committed to the array.

---
 rtl/register_write_queue.sv | 123 ++++++++++++
 tb/tb_register_write_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_write_queue.sv
// register_write_queue: in-order buffered write front-end for one register-file
// write port. Requests enter over valid/ready, sit in a DEPTH-entry circular
// FIFO and drain one per cycle unless stalled or flushed.
// Optional forwarding lookup over pending entries is enabled by defining the
// macro REGISTER_WRITE_QUEUE_FORWARD_EN; otherwise lookup outputs are tied to 0.
module register_write_queue #(
    parameter int N_BIT_DATA    = 32,
    parameter int N_BIT_ADDRESS = 16,
    parameter int DEPTH         = 8
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [N_BIT_ADDRESS-1:0]         req_address,
    input  logic [N_BIT_DATA-1:0]            req_data,
    input  logic                             stall,
    input  logic                             flush,
    output logic                             wr_enable,
    output logic [N_BIT_ADDRESS-1:0]         wr_address,
    output logic [N_BIT_DATA-1:0]            wr_data,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             empty,
    output logic                             full,
    input  logic [N_BIT_ADDRESS-1:0]         lookup_address,
    output logic                             lookup_hit,
    output logic [N_BIT_DATA-1:0]            lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [N_BIT_ADDRESS-1:0] address;
        logic [N_BIT_DATA-1:0]    data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;

    // A full queue never accepts, even if the head drains this cycle.
    assign req_ready = reset_n && !full && !flush;
    assign wr_enable = !empty && !stall && !flush;
    assign push      = req_valid && req_ready;
    assign pop       = wr_enable;

    assign wr_address = empty ? '0 : mem[rd_ptr_q].address;
    assign wr_data    = empty ? '0 : mem[rd_ptr_q].data;

    // Next-state for pointers and occupancy; flush empties the queue.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: cleared immediately by reset, otherwise follows next-state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // register samples pre-edge values regardless of block order.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: written on accept only.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; validity comes from count_q,
        // so stale contents are never observable.
        if (push) mem[wr_ptr_q] <= '{address: req_address, data: req_data};
    end

`ifdef REGISTER_WRITE_QUEUE_FORWARD_EN
    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem[idx].address == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem[idx].data;
            end
        end
    end
`else
    // Forwarding disabled: query address is ignored.
    logic unused_lookup;
    assign unused_lookup = ^lookup_address;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_register_write_queue.sv
// Testbench for register_write_queue: a queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_register_write_queue;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clock, reset_n;
    logic            req_valid, req_ready;
    logic [AW-1:0]   req_address;
    logic [DW-1:0]   req_data;
    logic            stall, flush;
    logic            wr_enable;
    logic [AW-1:0]   wr_address;
    logic [DW-1:0]   wr_data;
    logic [CW-1:0]   count;
    logic            empty, full;
    logic [AW-1:0]   lookup_address;
    logic            lookup_hit;
    logic [DW-1:0]   lookup_data;

    register_write_queue #(.N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_data(req_data),
        .stall(stall), .flush(flush),
        .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
        .count(count), .empty(empty), .full(full),
        .lookup_address(lookup_address), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];     // reference queue contents, oldest first
    ent_t wlog[$];   // writes observed on the write port
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: asynchronous reset empties the queue.
    always @(negedge reset_n) mq.delete();

    // Reference model: flush empties, otherwise pop head and/or append request.
    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            if (flush) mq.delete();
            else begin
                logic do_push, do_pop;
                do_push = req_valid && (mq.size() < DEPTH);
                do_pop  = (mq.size() > 0) && !stall;
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back('{a: req_address, d: req_data});
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic          e_hit;
        logic [DW-1:0] e_ld;
        int            n;
        n     = mq.size();
        e_hit = 1'b0;
        e_ld  = '0;
`ifdef REGISTER_WRITE_QUEUE_FORWARD_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (mq[i].a == lookup_address) begin
                e_hit = 1'b1;
                e_ld  = mq[i].d;
                break;
            end
        end
`endif
        check("m_req_ready", req_ready, (reset_n === 1'b1) && (n < DEPTH) && !flush);
        check("m_wr_enable", wr_enable, (n > 0) && !stall && !flush);
        check("m_wr_address", wr_address, (n > 0) ? mq[0].a : '0);
        check("m_wr_data", wr_data, (n > 0) ? mq[0].d : '0);
        check("m_count", count, n);
        check("m_empty", empty, n == 0);
        check("m_full", full, n == DEPTH);
        check("m_lookup_hit", lookup_hit, e_hit);
        check("m_lookup_data", lookup_data, e_ld);
        if (wr_enable === 1'b1) wlog.push_back('{a: wr_address, d: wr_data});
    end

    // Offer one request and hold it until accepted, with a bounded wait.
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        acc         = 1'b0;
        req_valid   = 1'b1;
        req_address = a;
        req_data    = d;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = req_ready;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check("push_accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        req_valid      = 1'b1;
        req_address    = 16'h0abc;
        req_data       = 32'h1234_5678;
        stall          = 1'b0;
        flush          = 1'b0;
        lookup_address = 16'h0abc;

        // Reset held 3 cycles with a request offered.
        idle(3);
        check("rst_ready", req_ready, 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        reset_n   = 1'b1;
        req_valid = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_wr_enable", wr_enable, 1'b0);
        idle(2);
        check("post_rst_no_writes", wlog.size(), 0);

        // Single write appears exactly one cycle after acceptance.
        wlog.delete();
        push(16'h0005, 32'hDEAD_BEEF);
        check("single_we_next_cycle", wr_enable, 1'b1);
        idle(3);
        check("single_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check("single_addr", wlog[0].a, 16'h0005);
            check("single_data", wlog[0].d, 32'hDEAD_BEEF);
        end

        // Fill under stall, then drain across pointer wrap while pushing 4 more.
        wlog.delete();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) push(AW'(16'h0100 + i), DW'(32'hA000 + i));
        check("fill_full", full, 1'b1);
        check("fill_ready", req_ready, 1'b0);
        check("fill_count", count, 8);
        stall = 1'b0;
        for (int i = 8; i < 12; i++) push(AW'(16'h0100 + i), DW'(32'hA000 + i));
        idle(12);
        check("wrap_nwrites", wlog.size(), 12);
        for (int i = 0; i < 12 && i < wlog.size(); i++) begin
            check("wrap_order_addr", wlog[i].a, 16'h0100 + i);
            check("wrap_order_data", wlog[i].d, 32'hA000 + i);
        end

        // Flush with 5 queued and a request offered.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push(AW'(16'h0200 + i), DW'(32'hB000 + i));
        check("preflush_count", count, 5);
        wlog.delete();
        stall       = 1'b0;
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_address = 16'h0300;
        req_data    = 32'hCCCC_0000;
        #1;
        check("flush_ready", req_ready, 1'b0);
        check("flush_wr_enable", wr_enable, 1'b0);
        @(posedge clock); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("postflush_count", count, 0);
        check("postflush_empty", empty, 1'b1);
        idle(3);
        check("postflush_no_writes", wlog.size(), 0);

        // Forwarding: youngest match wins.
        stall = 1'b1;
        push(16'h0010, 32'h11);
        push(16'h0010, 32'h22);
        push(16'h0020, 32'h33);
        lookup_address = 16'h0010;
        #1;
`ifdef REGISTER_WRITE_QUEUE_FORWARD_EN
        check("fwd_hit", lookup_hit, 1'b1);
        check("fwd_data", lookup_data, 32'h22);
`else
        check("fwd_hit_off", lookup_hit, 1'b0);
        check("fwd_data_off", lookup_data, 32'h0);
`endif
        lookup_address = 16'h0011;
        #1;
        check("fwd_miss", lookup_hit, 1'b0);
        stall = 1'b0;
        idle(5);

        // Asynchronous reset between edges with 3 entries queued.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push(AW'(16'h0400 + i), DW'(32'hD000 + i));
        check("premid_count", count, 3);
        wlog.delete();
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1'b1);
        check("midrst_wr_enable", wr_enable, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        stall   = 1'b0;
        idle(5);
        check("midrst_no_stale", wlog.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
